hazard_ctrl: RTL and testbench

// Pipeline sequencing controller for the 5-stage ARMv8 core. Drives write-enable/flush of
// PC, IF_ID, ID_EX, EX_MEM and MEM_WB, and selects the EX-stage forwarding muxes.

---
 rtl/arm_pipe_pkg.sv | 21 ++
 rtl/fwd_unit.sv | 40 ++++
 rtl/hazard_ctrl.sv | 174 +++++++++++++++++
 tb/tb_hazard_ctrl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/arm_pipe_pkg.sv
// ---------------------------------------------------------------------------
// arm_pipe_pkg
// Shared definitions for the 5-stage ARMv8 pipeline sequencing logic:
//   state_t  - hazard controller FSM states (RUN, MEM_WAIT)
//   FWD_*    - EX-stage operand forwarding mux selects
//   XZR      - register number of the zero register (never forwarded)
// ---------------------------------------------------------------------------
package arm_pipe_pkg;

   typedef enum logic {
      RUN      = 1'b0,
      MEM_WAIT = 1'b1
   } state_t;

   localparam logic [1:0] FWD_ID  = 2'b00;  // operand from ID_EX
   localparam logic [1:0] FWD_MEM = 2'b10;  // operand from EX_MEM
   localparam logic [1:0] FWD_WB  = 2'b01;  // operand from MEM_WB

   localparam logic [4:0] XZR = 5'd31;

endpackage

// File: rtl/fwd_unit.sv
// ---------------------------------------------------------------------------
// fwd_unit
// Combinational forwarding select for one EX-stage source operand.
// Ports:
//   i_src            source register of the EX instruction
//   i_mem_reg_write  MEM instruction writes a register
//   i_mem_rd         destination register of MEM instruction
//   i_wb_reg_write   WB instruction writes a register
//   i_wb_rd          destination register of WB instruction
//   o_sel            FWD_MEM / FWD_WB / FWD_ID
// ---------------------------------------------------------------------------
module fwd_unit
   import arm_pipe_pkg::*;
(
   input  logic [4:0] i_src,
   input  logic       i_mem_reg_write,
   input  logic [4:0] i_mem_rd,
   input  logic       i_wb_reg_write,
   input  logic [4:0] i_wb_rd,
   output logic [1:0] o_sel
);

   logic w_mem_hit;
   logic w_wb_hit;

   // XZR reads as zero, so a write to it must never be forwarded.
   assign w_mem_hit = i_mem_reg_write && (i_mem_rd != XZR) && (i_mem_rd == i_src);
   assign w_wb_hit  = i_wb_reg_write  && (i_wb_rd  != XZR) && (i_wb_rd  == i_src);

   // The younger result (EX_MEM) wins when both stages match.
   always_comb begin
      o_sel = FWD_ID;
      if (w_mem_hit) begin
         o_sel = FWD_MEM;
      end else if (w_wb_hit) begin
         o_sel = FWD_WB;
      end
   end

endmodule

// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl
// Pipeline sequencing controller for the 5-stage ARMv8 core. Drives the
// write-enable / flush controls of PC, IF_ID, ID_EX, EX_MEM and MEM_WB,
// selects the EX-stage forwarding muxes, freezes the pipe on data-memory
// waits (with timeout fault) and counts stalled cycles.
// Ports:
//   clock, reset                  rising-edge clock, sync active-high reset
//   id_rn/id_rm, id_use_rn/rm     sources of the ID instruction
//   ex_rn/ex_rm, ex_mem_read,
//   ex_rd                         EX instruction sources / load / dest
//   mem_reg_write, mem_rd         MEM instruction writeback
//   wb_reg_write, wb_rd           WB instruction writeback
//   branch_taken                  MEM-stage branch resolved taken
//   dmem_req, dmem_ready          data memory handshake
//   *_write, *_flush              pipeline register controls
//   fwd_a, fwd_b                  forwarding selects for rn / rm
//   mem_fault                     one-cycle pulse on memory timeout
//   stall_cnt                     saturating count of pc_write=0 cycles
// ---------------------------------------------------------------------------
module hazard_ctrl
   import arm_pipe_pkg::*;
#(
   parameter int MEM_TIMEOUT = 15,
   parameter int CNT_W       = 16
)(
   input  logic             clock,
   input  logic             reset,
   input  logic [4:0]       id_rn,
   input  logic [4:0]       id_rm,
   input  logic             id_use_rn,
   input  logic             id_use_rm,
   input  logic [4:0]       ex_rn,
   input  logic [4:0]       ex_rm,
   input  logic             ex_mem_read,
   input  logic [4:0]       ex_rd,
   input  logic             mem_reg_write,
   input  logic [4:0]       mem_rd,
   input  logic             wb_reg_write,
   input  logic [4:0]       wb_rd,
   input  logic             branch_taken,
   input  logic             dmem_req,
   input  logic             dmem_ready,
   output logic             pc_write,
   output logic             if_id_write,
   output logic             if_id_flush,
   output logic             id_ex_write,
   output logic             id_ex_flush,
   output logic             ex_mem_write,
   output logic             ex_mem_flush,
   output logic             mem_wb_flush,
   output logic [1:0]       fwd_a,
   output logic [1:0]       fwd_b,
   output logic             mem_fault,
   output logic [CNT_W-1:0] stall_cnt
);

   state_t           r_state;
   logic [7:0]       r_wait_cnt;
   logic             r_mem_fault;
   logic [CNT_W-1:0] r_stall_cnt;

   logic [7:0]       w_cur_cnt;
   logic             w_wait;
   logic             w_timeout;
   logic             w_frozen;
   logic             w_load_use;
   logic [1:0]       w_fwd_a;
   logic [1:0]       w_fwd_b;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   fwd_unit u_fwd_a (
      .i_src           (ex_rn),
      .i_mem_reg_write (mem_reg_write),
      .i_mem_rd        (mem_rd),
      .i_wb_reg_write  (wb_reg_write),
      .i_wb_rd         (wb_rd),
      .o_sel           (w_fwd_a)
   );

   fwd_unit u_fwd_b (
      .i_src           (ex_rm),
      .i_mem_reg_write (mem_reg_write),
      .i_mem_rd        (mem_rd),
      .i_wb_reg_write  (wb_reg_write),
      .i_wb_rd         (wb_rd),
      .o_sel           (w_fwd_b)
   );

   // The wait counter only carries meaning while a wait is in progress;
   // the first not-ready cycle seen from RUN is wait cycle 0.
   assign w_cur_cnt = (r_state == MEM_WAIT) ? r_wait_cnt : 8'd0;

   assign w_wait    = !reset && dmem_req && !dmem_ready;
   // On the last permitted wait cycle the access is abandoned instead of
   // frozen: the pipe advances and the MEM instruction becomes a bubble.
   assign w_timeout = w_wait && (w_cur_cnt == 8'(MEM_TIMEOUT - 1));
   assign w_frozen  = w_wait && !w_timeout;

   assign w_load_use = ex_mem_read && (ex_rd != XZR) &&
                       ((id_use_rn && (id_rn == ex_rd)) ||
                        (id_use_rm && (id_rm == ex_rd)));

   // Priority: reset > memory freeze > branch squash > load-use stall.
   always_comb begin
      pc_write     = 1'b1;
      if_id_write  = 1'b1;
      id_ex_write  = 1'b1;
      ex_mem_write = 1'b1;
      if_id_flush  = 1'b0;
      id_ex_flush  = 1'b0;
      ex_mem_flush = 1'b0;
      mem_wb_flush = 1'b0;
      fwd_a        = w_fwd_a;
      fwd_b        = w_fwd_b;
      if (reset) begin
         pc_write     = 1'b0;
         if_id_write  = 1'b0;
         id_ex_write  = 1'b0;
         ex_mem_write = 1'b0;
         if_id_flush  = 1'b1;
         id_ex_flush  = 1'b1;
         ex_mem_flush = 1'b1;
         mem_wb_flush = 1'b1;
         fwd_a        = FWD_ID;
         fwd_b        = FWD_ID;
      end else if (w_frozen) begin
         pc_write     = 1'b0;
         if_id_write  = 1'b0;
         id_ex_write  = 1'b0;
         ex_mem_write = 1'b0;
         mem_wb_flush = 1'b1;
      end else begin
         mem_wb_flush = w_timeout;
         if (branch_taken) begin
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
         end else if (w_load_use) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_flush = 1'b1;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state     <= RUN;
         r_wait_cnt  <= 8'd0;
         r_mem_fault <= 1'b0;
         r_stall_cnt <= '0;
      end else begin
         r_mem_fault <= w_timeout;
         if (w_frozen) begin
            r_state    <= MEM_WAIT;
            r_wait_cnt <= w_cur_cnt + 8'd1;
         end else begin
            r_state    <= RUN;
            r_wait_cnt <= 8'd0;
         end
         if (!pc_write) begin
            r_stall_cnt <= sat_inc(r_stall_cnt);
         end
      end
   end

   assign mem_fault = r_mem_fault;
   assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

   localparam int MEM_TIMEOUT = 15;
   localparam int CNT_W       = 5;
   localparam int STALL_MAX   = (1 << CNT_W) - 1;

   typedef struct packed {
      logic [7:0]       ctl;   // {pc_w, ifid_w, idex_w, exmem_w, ifid_f, idex_f, exmem_f, memwb_f}
      logic [1:0]       fa;
      logic [1:0]       fb;
      logic             flt;
      logic [CNT_W-1:0] sc;
   } exp_t;

   logic             clock = 1'b0;
   logic             reset;
   logic [4:0]       id_rn, id_rm, ex_rn, ex_rm, ex_rd, mem_rd, wb_rd;
   logic             id_use_rn, id_use_rm, ex_mem_read, mem_reg_write, wb_reg_write;
   logic             branch_taken, dmem_req, dmem_ready;
   logic             pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush;
   logic             ex_mem_write, ex_mem_flush, mem_wb_flush, mem_fault;
   logic [1:0]       fwd_a, fwd_b;
   logic [CNT_W-1:0] stall_cnt;

   exp_t sb[$];
   exp_t m_e;
   logic [7:0] act_ctl;
   int   n_checks = 0;
   int   n_fail   = 0;
   bit   done     = 1'b0;

   // Reference model state
   int m_waited = 0;
   bit m_fault  = 1'b0;
   int m_stall  = 0;

   hazard_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
      .clock(clock), .reset(reset),
      .id_rn(id_rn), .id_rm(id_rm), .id_use_rn(id_use_rn), .id_use_rm(id_use_rm),
      .ex_rn(ex_rn), .ex_rm(ex_rm), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
      .mem_reg_write(mem_reg_write), .mem_rd(mem_rd),
      .wb_reg_write(wb_reg_write), .wb_rd(wb_rd),
      .branch_taken(branch_taken), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
      .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
      .id_ex_write(id_ex_write), .id_ex_flush(id_ex_flush),
      .ex_mem_write(ex_mem_write), .ex_mem_flush(ex_mem_flush),
      .mem_wb_flush(mem_wb_flush), .fwd_a(fwd_a), .fwd_b(fwd_b),
      .mem_fault(mem_fault), .stall_cnt(stall_cnt)
   );

   always #5 clock = ~clock;

   function automatic logic [1:0] fwd_model(input logic [4:0] src);
      if (src == 5'd31) return 2'b00;
      if (mem_reg_write && mem_rd == src) return 2'b10;
      if (wb_reg_write && wb_rd == src) return 2'b01;
      return 2'b00;
   endfunction

   function automatic logic [4:0] rreg();
      int v;
      v = $urandom_range(0, 4);
      return (v == 4) ? 5'd31 : 5'(v);
   endfunction

   task automatic idle();
      reset = 0; id_rn = 0; id_rm = 0; id_use_rn = 0; id_use_rm = 0;
      ex_rn = 0; ex_rm = 0; ex_mem_read = 0; ex_rd = 0;
      mem_reg_write = 0; mem_rd = 0; wb_reg_write = 0; wb_rd = 0;
      branch_taken = 0; dmem_req = 0; dmem_ready = 1;
   endtask

   // Predict this cycle's outputs from the current inputs, queue them,
   // then advance the reference model across the clock edge.
   task automatic cycle();
      exp_t e;
      bit   waiting, timeout, frozen, lu;
      waiting = !reset && dmem_req && !dmem_ready;
      timeout = waiting && (m_waited == MEM_TIMEOUT - 1);
      frozen  = waiting && !timeout;
      lu = ex_mem_read && ex_rd != 5'd31 &&
           ((id_use_rn && id_rn == ex_rd) || (id_use_rm && id_rm == ex_rd));
      if (reset)             e.ctl = 8'b0000_1111;
      else if (frozen)       e.ctl = 8'b0000_0001;
      else if (branch_taken) e.ctl = {7'b1111_111, timeout};
      else if (lu)           e.ctl = {7'b0011_010, timeout};
      else                   e.ctl = {7'b1111_000, timeout};
      e.fa  = reset ? 2'b00 : fwd_model(ex_rn);
      e.fb  = reset ? 2'b00 : fwd_model(ex_rm);
      e.flt = m_fault;
      e.sc  = m_stall[CNT_W-1:0];
      sb.push_back(e);
      @(posedge clock);
      if (reset) begin
         m_waited = 0; m_fault = 0; m_stall = 0;
      end else begin
         m_fault  = timeout;
         m_waited = frozen ? m_waited + 1 : 0;
         if (!e.ctl[7]) m_stall = (m_stall >= STALL_MAX) ? STALL_MAX : m_stall + 1;
      end
      #1;
   endtask

   // Stimulus
   initial begin
      int stuck;
      idle();
      reset = 1;
      @(posedge clock);
      #1;
      // reset held two cycles, then release
      reset = 1; cycle(); cycle();
      reset = 0; cycle(); cycle();
      // load-use: LDUR X2 in EX, ADD X3,X2,X4 in ID
      ex_mem_read = 1; ex_rd = 2; id_rn = 2; id_use_rn = 1; id_rm = 4; id_use_rm = 1;
      cycle();
      idle(); ex_rn = 2; ex_rm = 4; wb_reg_write = 1; wb_rd = 2; cycle();
      // load to XZR never stalls
      idle(); ex_mem_read = 1; ex_rd = 31; id_rn = 31; id_use_rn = 1; cycle();
      // forwarding priority
      idle(); mem_reg_write = 1; wb_reg_write = 1; mem_rd = 5; wb_rd = 5; ex_rn = 5; ex_rm = 5; cycle();
      mem_rd = 31; wb_rd = 31; ex_rn = 31; ex_rm = 31; cycle();
      mem_rd = 6; wb_rd = 5; ex_rn = 5; ex_rm = 6; cycle();
      // branch squash suppresses a same-cycle load-use
      idle(); branch_taken = 1; ex_mem_read = 1; ex_rd = 7; id_rm = 7; id_use_rm = 1; cycle();
      idle(); cycle();
      // memory wait: three not-ready cycles then ready
      reset = 1; cycle(); reset = 0;
      dmem_req = 1; dmem_ready = 0; cycle(); cycle(); cycle();
      dmem_ready = 1; cycle();
      idle(); cycle();
      // load-use during a wait is applied on the ready cycle
      dmem_req = 1; dmem_ready = 0; ex_mem_read = 1; ex_rd = 3; id_rn = 3; id_use_rn = 1;
      cycle(); cycle();
      dmem_ready = 1; cycle();
      // timeout
      idle(); dmem_req = 1; dmem_ready = 0;
      for (int i = 0; i < MEM_TIMEOUT + 1; i++) cycle();
      idle(); cycle(); cycle();
      // reset in the middle of a wait
      dmem_req = 1; dmem_ready = 0;
      for (int i = 0; i < 5; i++) cycle();
      reset = 1; cycle();
      reset = 0;
      for (int i = 0; i < MEM_TIMEOUT + 2; i++) begin
         dmem_req = (i < 3); cycle();
      end
      // stall counter saturation
      idle(); ex_mem_read = 1; ex_rd = 1; id_rn = 1; id_use_rn = 1;
      for (int i = 0; i < STALL_MAX + 4; i++) cycle();
      // random traffic
      stuck = 0;
      for (int i = 0; i < 1500; i++) begin
         reset = ($urandom_range(0, 63) == 0);
         id_rn = rreg(); id_rm = rreg(); ex_rn = rreg(); ex_rm = rreg();
         ex_rd = rreg(); mem_rd = rreg(); wb_rd = rreg();
         id_use_rn = 1'($urandom_range(0, 1)); id_use_rm = 1'($urandom_range(0, 1));
         ex_mem_read = 1'($urandom_range(0, 1));
         mem_reg_write = 1'($urandom_range(0, 1)); wb_reg_write = 1'($urandom_range(0, 1));
         branch_taken = ($urandom_range(0, 5) == 0);
         if (stuck > 0) begin
            dmem_req = 1; dmem_ready = 0; stuck--;
         end else begin
            dmem_req   = 1'($urandom_range(0, 1));
            dmem_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 49) == 0) stuck = $urandom_range(8, 20);
         end
         cycle();
      end
      idle();
      done = 1'b1;
   end

   // Monitor / scoreboard
   initial begin
      forever begin
         @(negedge clock);
         if (sb.size() != 0) begin
            m_e = sb.pop_front();
            act_ctl = {pc_write, if_id_write, id_ex_write, ex_mem_write,
                       if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush};
            n_checks++;
            if (act_ctl !== m_e.ctl) begin
               n_fail++;
               $display("FAIL ctl t=%0t actual=%b expected=%b", $time, act_ctl, m_e.ctl);
            end
            n_checks++;
            if (fwd_a !== m_e.fa) begin
               n_fail++;
               $display("FAIL fwd_a t=%0t actual=%b expected=%b", $time, fwd_a, m_e.fa);
            end
            n_checks++;
            if (fwd_b !== m_e.fb) begin
               n_fail++;
               $display("FAIL fwd_b t=%0t actual=%b expected=%b", $time, fwd_b, m_e.fb);
            end
            n_checks++;
            if (mem_fault !== m_e.flt) begin
               n_fail++;
               $display("FAIL mem_fault t=%0t actual=%b expected=%b", $time, mem_fault, m_e.flt);
            end
            n_checks++;
            if (stall_cnt !== m_e.sc) begin
               n_fail++;
               $display("FAIL stall_cnt t=%0t actual=%0d expected=%0d", $time, stall_cnt, m_e.sc);
            end
         end
         if (done) begin
            n_checks++;
            if (sb.size() != 0) begin
               n_fail++;
               $display("FAIL scoreboard_drain actual=%0d expected=0", sb.size());
            end
            $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
            $finish;
         end
      end
   end

endmodule
